seg_scan_capture: RTL and testbench
===================================

# seg_scan_capture

Receive-side counterpart to the multiplexed seven-segment display driver in the clock design. Samples the scanned segment bus and digit-select lines and decodes each stable segment pattern back into a hex nibble. Rebuilds the full displayed value as a parallel word. Used in loopback self-check and on the bench to confirm the digits actually driven to the display.

## Interface

Parameters:
- DIGITS, 4, number of scanned digit positions, legal range 1..8.
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted, legal range 2..255.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous active-low reset.
- segment  input  7  segment lines, active-high; bit0=a, bit1=b … bit6=g.
- digit_sel  input  3  index of the digit currently driven; values >= DIGITS mean "no digit".
- err_clr  input  1  synchronous clear of err; has priority over a same-cycle error set.
- digits  output  4*DIGITS  decoded nibbles; digit i occupies bits [4i+3:4i].
- digit_valid  output  DIGITS  bit i set once digit i holds a decoded non-blank value.
- frame_done  output  1  one-cycle pulse when every digit position has been captured since the previous pulse.
- err  output  1  sticky; set on an undecodable stable pattern.

## Operation

- Input stage: segment and digit_sel are registered once into in_q, which holds 10 bits. All decisions use in_q.
- Stability counter (8-bit):
  - Set to 1 on the first edge after reset, and on any edge where the new in_q differs from the previous in_q.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Accept event:
  - Occurs on the edge where the counter goes from STABLE_CYCLES-1 to STABLE_CYCLES.
  - Exactly once per stable period. A held pattern is never recaptured.
- On accept with idx = digit_sel from in_q:
  - idx >= DIGITS: ignored. No digit update, no error, no frame tracking.
  - Pattern in decode table: digits[idx] is loaded with the nibble, digit_valid[idx] is set, and seen[idx] is set.
  - Pattern 0x00 (blank): digits[idx] is unchanged, digit_valid[idx] is cleared, and seen[idx] is set.
  - Any other pattern: err is set, and digits, digit_valid and seen are unchanged.
- Decode table (pattern→nibble): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F.
- Frame tracking:
  - The internal mask seen[DIGITS-1:0] records which positions have been captured.
  - When an accept makes seen all-ones, frame_done pulses on the following cycle and seen clears in that same edge.
  - Capture order is irrelevant. Repeat captures of one position within a frame are allowed.
- err_clr: err goes 0 on the next edge, even if an error accept happens in the same cycle.

## Timing

- Reset (asynchronous assert, synchronous-release use) clears in_q, counter, seen, digits (all zero), digit_valid (all zero), frame_done=0 and err=0.
- Latency: a pattern first present at the inputs before edge N is in in_q after edge N. It is accepted at edge N+STABLE_CYCLES-1, so digits/digit_valid/err update on that edge.
  - Minimum input hold time is therefore STABLE_CYCLES clocks.
- frame_done is a registered pulse: high for exactly one cycle, starting one edge after the completing accept.
- Glitch rejection: any change shorter than STABLE_CYCLES clocks produces no accept. The glitch also restarts the count for the surrounding pattern.
- A change of digit_sel alone, with segment unchanged, restarts the count.
- Reset asserted mid-count or mid-frame discards all progress immediately. Outputs return to their reset values without waiting for a clock.
- No combinational path from inputs to outputs.

## Test plan

- Reset then hold segment=0x06, digit_sel=0 (STABLE_CYCLES=4) → digits[3:0]=1 and digit_valid=0001 exactly 4 edges after the first sample; no further change while held.
- Scan 3F/06/5B/4F on digits 0..3, 6 clocks each → digits=16'h3210, digit_valid=1111, and one frame_done pulse 1 cycle after the digit-3 accept. Repeat the scan → a second single pulse.
- Present 0x06 for 3 clocks then 0x7F for 6 clocks on digit 2 → only 8 is captured (digits[11:8]=8); the 1 never appears.
- Stable 0x55 on digit 1 → err=1 and digits unchanged. Assert err_clr for 1 cycle → err=0. Raise err_clr in the same cycle as a new 0x55 accept → err stays 0.
- After digit 0 holds 7, present 0x00 on digit 0 → digit_valid[0]=0, digits[3:0] still 7, and seen bit 0 counts toward frame_done.
- digit_sel=5 with 0x7F held for 10 clocks → no output change. Assert reset mid-scan after digits 0-2 are captured, release, then capture only digit 3 → no frame_done.

Source files
------------

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: samples a scanned seven-segment bus and rebuilds the displayed hex word.
module seg_scan_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [6:0]            segment,
  input  logic [2:0]            digit_sel,
  input  logic                  err_clr,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  frame_done,
  output logic                  err
);
  localparam logic [7:0] SC = 8'(STABLE_CYCLES);

  logic [9:0]              in_q, in_d;
  logic                    started_q;
  logic [7:0]              cnt_q, cnt_d;
  logic [DIGITS-1:0][3:0]  dig_q, dig_d;
  logic [DIGITS-1:0]       val_q, val_d, seen_q, seen_d;
  logic                    frame_q, frame_d, err_q, err_d;
  logic                    accept, known, blank, in_range;
  logic [3:0]              nib;

  assign in_d     = {digit_sel, segment};
  assign cnt_d    = (!started_q || in_d != in_q) ? 8'd1 : (cnt_q == SC ? cnt_q : cnt_q + 8'd1);
  // Fires only on the edge that lifts the count from SC-1 to SC, so a held pattern is taken once.
  assign accept   = started_q && in_d == in_q && cnt_q == SC - 8'd1;
  assign blank    = in_q[6:0] == 7'h00;
  assign in_range = {5'd0, in_q[9:7]} < 8'(DIGITS);
  assign frame_d  = &seen_q;

  always_comb begin
    known = 1'b1;
    nib   = 4'h0;
    case (in_q[6:0])
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: known = 1'b0;
    endcase
  end

  always_comb begin
    dig_d  = dig_q;
    val_d  = val_q;
    seen_d = frame_d ? '0 : seen_q;
    err_d  = !err_clr && (err_q || (accept && in_range && !known && !blank));
    for (int i = 0; i < DIGITS; i++) begin
      if (accept && in_q[9:7] == 3'(i) && (known || blank)) begin
        seen_d[i] = 1'b1;
        val_d[i]  = known;
        dig_d[i]  = known ? nib : dig_q[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_q      <= '0;
      started_q <= 1'b0;
      cnt_q     <= '0;
      dig_q     <= '0;
      val_q     <= '0;
      seen_q    <= '0;
      frame_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      in_q      <= in_d;
      started_q <= 1'b1;
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      val_q     <= val_d;
      seen_q    <= seen_d;
      frame_q   <= frame_d;
      err_q     <= err_d;
    end
  end

  assign digits      = dig_q;
  assign digit_valid = val_q;
  assign frame_done  = frame_q;
  assign err         = err_q;
endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed vectors and hand sequences for seg_scan_capture (DIGITS=4, STABLE_CYCLES=4).
module tb_seg_scan_capture;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  segment = 7'h06;
  logic [2:0]  digit_sel = 3'd0;
  logic        err_clr = 1'b0;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        frame_done;
  logic        err;
  int          tests = 0;
  int          fails = 0;
  int          frames = 0;

  typedef struct {
    logic [6:0]  seg;
    logic [2:0]  sel;
    int          cyc;
    logic [15:0] dig;
    logic [3:0]  val;
    logic        er;
    int          fr;
  } vec_t;
  vec_t tbl[16];

  seg_scan_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .segment(segment), .digit_sel(digit_sel),
    .err_clr(err_clr), .digits(digits), .digit_valid(digit_valid),
    .frame_done(frame_done), .err(err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (frame_done) frames++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic [6:0] seg, input logic [2:0] sel, input int n);
    segment   = seg;
    digit_sel = sel;
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    tbl[0]  = '{7'h3F, 3'd0, 6,  16'h0000, 4'b0001, 1'b0, 0};
    tbl[1]  = '{7'h06, 3'd1, 6,  16'h0010, 4'b0011, 1'b0, 0};
    tbl[2]  = '{7'h5B, 3'd2, 6,  16'h0210, 4'b0111, 1'b0, 0};
    tbl[3]  = '{7'h4F, 3'd3, 6,  16'h3210, 4'b1111, 1'b0, 1};
    tbl[4]  = '{7'h3F, 3'd0, 6,  16'h3210, 4'b1111, 1'b0, 1};
    tbl[5]  = '{7'h06, 3'd1, 6,  16'h3210, 4'b1111, 1'b0, 1};
    tbl[6]  = '{7'h5B, 3'd2, 6,  16'h3210, 4'b1111, 1'b0, 1};
    tbl[7]  = '{7'h4F, 3'd3, 6,  16'h3210, 4'b1111, 1'b0, 2};
    tbl[8]  = '{7'h06, 3'd2, 3,  16'h3210, 4'b1111, 1'b0, 2};
    tbl[9]  = '{7'h7F, 3'd2, 6,  16'h3810, 4'b1111, 1'b0, 2};
    tbl[10] = '{7'h07, 3'd0, 6,  16'h3817, 4'b1111, 1'b0, 2};
    tbl[11] = '{7'h00, 3'd0, 6,  16'h3817, 4'b1110, 1'b0, 2};
    tbl[12] = '{7'h06, 3'd1, 6,  16'h3817, 4'b1110, 1'b0, 2};
    tbl[13] = '{7'h4F, 3'd3, 6,  16'h3817, 4'b1110, 1'b0, 3};
    tbl[14] = '{7'h7F, 3'd5, 10, 16'h3817, 4'b1110, 1'b0, 3};
    tbl[15] = '{7'h55, 3'd1, 6,  16'h3817, 4'b1110, 1'b1, 3};

    repeat (2) @(posedge clock);
    #1;
    chk("reset_digits", 32'(digits), 32'h0);
    chk("reset_valid", 32'(digit_valid), 32'h0);
    chk("reset_frame", 32'(frame_done), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    reset = 1'b1;
    hold(7'h06, 3'd0, 3);
    chk("first_pre_accept_valid", 32'(digit_valid), 32'h0);
    hold(7'h06, 3'd0, 1);
    chk("first_accept_digits", 32'(digits), 32'h0001);
    chk("first_accept_valid", 32'(digit_valid), 32'h1);
    hold(7'h06, 3'd0, 5);
    chk("first_held_digits", 32'(digits), 32'h0001);
    chk("first_held_valid", 32'(digit_valid), 32'h1);

    for (int i = 0; i < 16; i++) begin
      hold(tbl[i].seg, tbl[i].sel, tbl[i].cyc);
      chk($sformatf("vec%0d_digits", i), 32'(digits), 32'(tbl[i].dig));
      chk($sformatf("vec%0d_valid", i), 32'(digit_valid), 32'(tbl[i].val));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].er));
      chk($sformatf("vec%0d_frames", i), 32'(frames), 32'(tbl[i].fr));
    end

    err_clr = 1'b1;
    hold(7'h55, 3'd1, 1);
    err_clr = 1'b0;
    chk("err_clr", 32'(err), 32'h0);
    hold(7'h55, 3'd0, 3);
    err_clr = 1'b1;
    hold(7'h55, 3'd0, 1);
    err_clr = 1'b0;
    chk("err_clr_priority", 32'(err), 32'h0);
    hold(7'h55, 3'd0, 3);
    chk("err_after_priority", 32'(err), 32'h0);
    chk("err_digits_kept", 32'(digits), 32'h3817);

    hold(7'h3F, 3'd0, 6);
    hold(7'h06, 3'd1, 6);
    hold(7'h5B, 3'd2, 6);
    hold(7'h4F, 3'd3, 4);
    chk("frame_at_accept", 32'(frame_done), 32'h0);
    chk("frame_accept_digits", 32'(digits), 32'h3210);
    hold(7'h4F, 3'd3, 1);
    chk("frame_pulse_high", 32'(frame_done), 32'h1);
    hold(7'h4F, 3'd3, 1);
    chk("frame_pulse_low", 32'(frame_done), 32'h0);
    chk("frame_count", 32'(frames), 32'd4);

    hold(7'h3F, 3'd0, 6);
    hold(7'h06, 3'd1, 6);
    hold(7'h5B, 3'd2, 6);
    segment   = 7'h4F;
    digit_sel = 3'd3;
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_digits", 32'(digits), 32'h0);
    chk("async_reset_valid", 32'(digit_valid), 32'h0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    hold(7'h4F, 3'd3, 8);
    chk("post_reset_digits", 32'(digits), 32'h3000);
    chk("post_reset_valid", 32'(digit_valid), 32'h8);
    chk("post_reset_no_frame", 32'(frames), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
